// File: rtl/time_pkg.sv
// Shared definitions for the time-measurement blocks.
package time_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        MEASURE    = 2'd2,
        RESULT     = 2'd3
    } meter_state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a signal already synchronous to clk.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // History updates every cycle so a held-high level yields a single edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/interval_meter.sv
// Counts tick-enable pulses between two rising edges of sig_i and hands the
// result over a valid/ready interface, saturating at a per-measurement limit.
module interval_meter
    import time_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm_i,
    input  logic [DW-1:0] limit_i,
    input  logic          sig_i,
    input  logic          en_i,
    input  logic          clr_i,
    output logic [DW-1:0] count_o,
    output logic          overflow_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic          busy_o
);

    meter_state_t  state;
    meter_state_t  next_state;
    logic [DW-1:0] counter;
    logic [DW-1:0] limit;
    logic [DW:0]   n;
    logic          over;
    logic          rise;

    edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (sig_i),
        .rise (rise)
    );

    // One extra bit keeps an all-ones limit from wrapping the comparison.
    assign n    = {1'b0, counter} + {{DW{1'b0}}, en_i};
    assign over = n > {1'b0, limit};

    always_comb begin
        next_state = state;
        if (clr_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:       if (arm_i)        next_state = WAIT_START;
                WAIT_START: if (rise)         next_state = MEASURE;
                MEASURE:    if (over || rise) next_state = RESULT;
                RESULT:     if (ready_i)      next_state = IDLE;
                default:                      next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Overflow is tested before the stop edge so saturation wins a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter    <= '0;
            limit      <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else if (!clr_i) begin
            case (state)
                IDLE: begin
                    if (arm_i) begin
                        limit <= limit_i;
                    end
                end
                WAIT_START: begin
                    if (rise) begin
                        counter <= '0;
                    end
                end
                MEASURE: begin
                    if (over) begin
                        count_o    <= limit;
                        overflow_o <= 1'b1;
                    end else if (rise) begin
                        count_o    <= n[DW-1:0];
                        overflow_o <= 1'b0;
                    end else begin
                        counter <= n[DW-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid_o = (state == RESULT);
    assign busy_o  = (state != IDLE);

endmodule

// File: tb/tb_interval_meter.sv
// Randomised scoreboard bench for interval_meter with a cumulative-tick reference model.
module tb_interval_meter;

    localparam int DW = 8;

    typedef struct {
        int count;
        int ovf;
        int vcyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          arm_i;
    logic [DW-1:0] limit_i;
    logic          sig_i;
    logic          en_i;
    logic          clr_i;
    logic [DW-1:0] count_o;
    logic          overflow_o;
    logic          valid_o;
    logic          ready_i;
    logic          busy_o;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    exp_t sb[$];

    interval_meter #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm_i      (arm_i),
        .limit_i    (limit_i),
        .sig_i      (sig_i),
        .en_i       (en_i),
        .clr_i      (clr_i),
        .count_o    (count_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks first-valid timing, result stability and the popped result.
    logic prev_valid = 1'b0;
    int   held_count = 0;
    int   held_ovf = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (valid_o && !prev_valid) begin
                if (sb.size() == 0) begin
                    check_output("unexpected_valid", 1, 0);
                end else begin
                    check_output("valid_latency", cyc, sb[0].vcyc);
                end
                held_count = int'(count_o);
                held_ovf   = int'(overflow_o);
            end else if (valid_o && prev_valid) begin
                check_output("count_hold", int'(count_o), held_count);
                check_output("overflow_hold", int'(overflow_o), held_ovf);
            end
            if (valid_o && ready_i && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check_output("count", int'(count_o), e.count);
                check_output("overflow", int'(overflow_o), e.ovf);
            end
            prev_valid = valid_o;
        end
    end

    // One measurement: arm, optional ignored edge in the arm cycle, start edge,
    // gap cycles to the stop edge, then hold cycles of backpressure before accept.
    task automatic apply_stimulus(input int lim, input int gap, input int w, input int pre,
                                  input int en_mode, input bit arm_edge, input int hold);
        bit   en_arr[0:299];
        int   cum;
        int   res_j;
        bit   ovf;
        int   t;
        exp_t e;
        for (int j = 1; j <= gap; j++) begin
            case (en_mode)
                0:       en_arr[j] = 1'b1;
                1:       en_arr[j] = (j % 4 == 0);
                2:       en_arr[j] = 1'($urandom_range(0, 1));
                default: en_arr[j] = 1'b0;
            endcase
        end
        cum   = 0;
        ovf   = 1'b0;
        res_j = gap;
        for (int j = 1; j <= gap; j++) begin
            cum += int'(en_arr[j]);
            if (cum > lim) begin
                ovf   = 1'b1;
                res_j = j;
                break;
            end
        end

        step();
        arm_i   = 1'b1;
        limit_i = DW'(lim);
        sig_i   = arm_edge;
        en_i    = 1'($urandom_range(0, 1));
        step();
        arm_i   = 1'b0;
        limit_i = DW'($urandom);
        sig_i   = 1'b0;
        for (int p = 0; p < pre; p++) begin
            step();
            en_i = 1'($urandom_range(0, 1));
        end
        step();
        sig_i  = 1'b1;
        en_i   = 1'($urandom_range(0, 1));
        e.count = ovf ? lim : cum;
        e.ovf   = int'(ovf);
        e.vcyc  = cyc + res_j + 1;
        sb.push_back(e);
        for (int j = 1; j <= gap; j++) begin
            step();
            en_i  = en_arr[j];
            sig_i = (j < w || j == gap);
        end
        step();
        en_i = 1'b0;
        t = 0;
        while (!valid_o && t < 50) begin
            step();
            t++;
        end
        if (!valid_o) begin
            check_output("valid_timeout", 0, 1);
            finish_run();
        end
        for (int h = 0; h < hold; h++) begin
            step();
            sig_i = 1'($urandom_range(0, 1));
            arm_i = 1'($urandom_range(0, 1));
            en_i  = 1'($urandom_range(0, 1));
        end
        step();
        ready_i = 1'b1;
        arm_i   = 1'b0;
        step();
        ready_i = 1'b0;
        sig_i   = 1'b0;
        en_i    = 1'b0;
        check_output("busy_after_accept", int'(busy_o), 0);
        check_output("valid_after_accept", int'(valid_o), 0);
        step();
    endtask

    initial begin
        rst     = 1'b1;
        arm_i   = 1'b0;
        limit_i = '0;
        sig_i   = 1'b0;
        en_i    = 1'b0;
        clr_i   = 1'b0;
        ready_i = 1'b0;
        step();
        step();
        check_output("reset_busy", int'(busy_o), 0);
        check_output("reset_valid", int'(valid_o), 0);
        check_output("reset_count", int'(count_o), 0);
        check_output("reset_overflow", int'(overflow_o), 0);
        rst = 1'b0;

        apply_stimulus(200, 10, 3, 0, 0, 1'b0, 2);
        apply_stimulus(200, 40, 5, 1, 1, 1'b0, 3);
        apply_stimulus(5, 20, 2, 0, 0, 1'b0, 1);
        apply_stimulus(5, 6, 2, 0, 0, 1'b0, 1);
        apply_stimulus(100, 12, 4, 2, 2, 1'b0, 20);
        apply_stimulus(0, 3, 1, 0, 3, 1'b0, 0);
        apply_stimulus(0, 5, 1, 0, 0, 1'b0, 0);
        apply_stimulus(50, 8, 2, 1, 0, 1'b1, 0);
        apply_stimulus(255, 260, 2, 0, 0, 1'b0, 0);

        // Abort from WAIT_START, then from MEASURE; no result may appear.
        step();
        arm_i   = 1'b1;
        limit_i = 8'd50;
        step();
        arm_i = 1'b0;
        step();
        check_output("busy_wait_start", int'(busy_o), 1);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check_output("clr_wait_start_busy", int'(busy_o), 0);
        check_output("clr_wait_start_valid", int'(valid_o), 0);
        step();
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
        step();
        sig_i = 1'b1;
        step();
        sig_i = 1'b0;
        en_i  = 1'b1;
        step();
        check_output("busy_measure", int'(busy_o), 1);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        check_output("clr_measure_busy", int'(busy_o), 0);
        sig_i = 1'b1;
        step();
        sig_i = 1'b0;
        en_i  = 1'b0;
        step();
        check_output("clr_measure_valid", int'(valid_o), 0);
        check_output("clr_measure_idle", int'(busy_o), 0);

        // Asynchronous reset in the middle of a measurement.
        apply_stimulus(200, 7, 2, 0, 0, 1'b0, 0);
        step();
        arm_i   = 1'b1;
        limit_i = 8'd100;
        step();
        arm_i = 1'b0;
        step();
        sig_i = 1'b1;
        step();
        sig_i = 1'b0;
        en_i  = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_busy", int'(busy_o), 0);
        check_output("async_rst_valid", int'(valid_o), 0);
        check_output("async_rst_count", int'(count_o), 0);
        check_output("async_rst_overflow", int'(overflow_o), 0);
        en_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(2, 60);
            apply_stimulus($urandom_range(0, 255), gap, $urandom_range(1, gap - 1),
                           $urandom_range(0, 3), $urandom_range(0, 3),
                           1'($urandom_range(0, 1)), $urandom_range(0, 5));
        end

        step();
        check_output("scoreboard_empty", sb.size(), 0);
        finish_run();
    end

    initial begin
        #1000000;
        check_output("global_timeout", 0, 1);
        finish_run();
    end

endmodule
